// File: rtl/io_freeze_sequencer_pkg.sv
// Shared encodings, default widths and zero-extension helper for the I/O freeze sequencer.
package io_seq_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_IN  = 2'd1;
  localparam logic [1:0] ST_WAIT_OUT = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam int DATA_W_DEF     = 32;
  localparam int SW_W_DEF       = 16;
  localparam int CNT_W_DEF      = 16;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int ZEXT_MAX_W     = 64;

  // Keep only the low w bits of v; callers cast to their own width.
  function automatic logic [ZEXT_MAX_W-1:0] zext(input logic [ZEXT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ZEXT_MAX_W-1:0] m;
    m = (w >= ZEXT_MAX_W) ? '1 : ((ZEXT_MAX_W'(1) << w) - ZEXT_MAX_W'(1));
    return v & m;
  endfunction

endpackage

// File: rtl/io_freeze_sequencer_if.sv
// Control-unit / user-I/O bundle seen by the freeze sequencer.
interface io_freeze_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 16,
  parameter int CNT_W  = 16
);
  logic              req_in;
  logic              req_out;
  logic              botao;
  logic [SW_W-1:0]   switches;
  logic [DATA_W-1:0] out_data;
  logic              congela;
  logic [DATA_W-1:0] in_data;
  logic              in_we;
  logic [DATA_W-1:0] disp_reg;
  logic [CNT_W-1:0]  io_count;
  logic              conflict;

  modport master (
    output req_in, req_out, botao, switches, out_data,
    input  congela, in_data, in_we, disp_reg, io_count, conflict
  );

  modport slave (
    input  req_in, req_out, botao, switches, out_data,
    output congela, in_data, in_we, disp_reg, io_count, conflict
  );
endinterface

// File: rtl/io_freeze_sequencer_key_conditioner.sv
// Enter-key conditioner: 2-FF synchroniser, optional debounce (IO_DEBOUNCE_EN), rising-edge pulse.
module key_conditioner #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_press
);
  logic r_sync1, r_sync2, r_prev;
  logic w_key_q;

  // History resets high so a key held through reset is never taken as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  logic [DCW-1:0] r_cnt;
  logic           r_key_q;

  // Flip only after DEB_CYCLES consecutive samples disagreeing with the current level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_key_q <= 1'b1;
    end else if (r_sync2 == r_key_q) begin
      r_cnt <= '0;
    end else if (r_cnt == DCW'(DEB_CYCLES - 1)) begin
      r_cnt   <= '0;
      r_key_q <= r_sync2;
    end else begin
      r_cnt <= r_cnt + DCW'(1);
    end
  end

  assign w_key_q = r_key_q;
`else
  assign w_key_q = r_sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= w_key_q;
  end

  assign o_press = w_key_q & ~r_prev;
endmodule

// File: rtl/io_freeze_sequencer.sv
// Freezes the core on IN/OUT until a fresh Enter press, then releases it for one commit cycle.
// Enter debounce is enabled by defining IO_DEBOUNCE_EN.
module io_freeze_sequencer
  import io_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SW_W       = SW_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  io_freeze_sequencer_if.slave bus
);
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_in_data;
  logic              r_in_we;
  logic [DATA_W-1:0] r_disp;
  logic [CNT_W-1:0]  r_count;
  logic              r_conflict;
  logic              w_press;
  logic [DATA_W-1:0] w_sw_ext;

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk     (clk),
    .reset   (reset),
    .i_key   (bus.botao),
    .o_press (w_press)
  );

  assign w_sw_ext = DATA_W'(zext(ZEXT_MAX_W'(bus.switches), SW_W));

  // Presses outside WAIT_* are dropped, so a key already high on entry needs a re-press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_data  <= '0;
      r_in_we    <= 1'b0;
      r_disp     <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_in_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_in) begin
            r_state <= ST_WAIT_IN;
            if (bus.req_out) r_conflict <= 1'b1;
          end else if (bus.req_out) begin
            r_state <= ST_WAIT_OUT;
            r_disp  <= bus.out_data;
          end
        end
        ST_WAIT_IN: begin
          if (w_press) begin
            r_in_data <= w_sw_ext;
            r_in_we   <= 1'b1;
            r_count   <= r_count + CNT_W'(1);
            r_state   <= ST_RELEASE;
          end
        end
        ST_WAIT_OUT: begin
          if (w_press) begin
            r_count <= r_count + CNT_W'(1);
            r_state <= ST_RELEASE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.congela  = (r_state == ST_WAIT_IN) || (r_state == ST_WAIT_OUT);
  assign bus.in_data  = r_in_data;
  assign bus.in_we    = r_in_we;
  assign bus.disp_reg = r_disp;
  assign bus.io_count = r_count;
  assign bus.conflict = r_conflict;
endmodule

// File: tb/tb_io_freeze_sequencer.sv
// Self-checking bench for io_freeze_sequencer; builds with or without IO_DEBOUNCE_EN.
module tb_io_freeze_sequencer;
  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int CNT_W  = 4;   // narrow counter so wrap-around is reachable quickly
  localparam int DEB    = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int REL_LAT = DEB + 3;
  localparam int SETTLE  = DEB + 4;
`else
  localparam int REL_LAT = 3;
  localparam int SETTLE  = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_freeze_sequencer_if #(.DATA_W(DATA_W), .SW_W(SW_W), .CNT_W(CNT_W)) bus ();

  io_freeze_sequencer #(.DATA_W(DATA_W), .SW_W(SW_W), .CNT_W(CNT_W), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show between transactions.
  logic [DATA_W-1:0] m_in, m_disp;
  int                m_cnt;
  logic              m_conf;

  task automatic model_clear();
    m_in = '0; m_disp = '0; m_cnt = 0; m_conf = 1'b0;
  endtask

  task automatic model_request(input bit ri, input bit ro, input logic [DATA_W-1:0] od);
    if (ri && ro) m_conf = 1'b1;
    if (!ri && ro) m_disp = od;
  endtask

  task automatic model_commit(input bit ri, input logic [SW_W-1:0] sw);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (ri) m_in = DATA_W'(sw);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_in = 1'b0; bus.req_out = 1'b0; bus.botao = 1'b0;
    bus.switches = '0; bus.out_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_clear();
  endtask

  // Called at a negedge; returns congela before and one edge after the request.
  task automatic start_req(input bit ri, input bit ro, input logic [SW_W-1:0] sw,
                           input logic [DATA_W-1:0] od, output logic cg0, output logic cg1);
    bus.req_in = ri; bus.req_out = ro; bus.switches = sw; bus.out_data = od;
    cg0 = bus.congela;
    @(posedge clk); #1;
    cg1 = bus.congela;
    model_request(ri, ro, od);
    @(negedge clk);
  endtask

  // Press Enter and measure edges until congela drops; optionally keep the request level held.
  task automatic press(input bit keep_req, output int lat, output logic we_rel, output logic we_after);
    lat = -1; we_rel = 1'b0; we_after = 1'b1;
    bus.botao = 1'b1;
    for (int c = 1; c <= REL_LAT + 20; c++) begin
      @(posedge clk); #1;
      if (!bus.congela) begin
        lat = c; we_rel = bus.in_we;
        break;
      end
    end
    if (!keep_req) begin bus.req_in = 1'b0; bus.req_out = 1'b0; end
    @(posedge clk); #1;
    we_after = bus.in_we;
    @(negedge clk);
    bus.botao = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.congela !== 1'b0) begin errors++; $display("FAIL reset_congela got %b want 0", bus.congela); end
    checks++; if (bus.in_we !== 1'b0) begin errors++; $display("FAIL reset_in_we got %b want 0", bus.in_we); end
    checks++; if (bus.in_data !== '0) begin errors++; $display("FAIL reset_in_data got %h want 0", bus.in_data); end
    checks++; if (bus.disp_reg !== '0) begin errors++; $display("FAIL reset_disp got %h want 0", bus.disp_reg); end
    checks++; if (bus.io_count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", bus.io_count); end
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", bus.conflict); end
  endtask

  task automatic test_in();
    logic cg0, cg1, we, wa; int lat;
    start_req(1, 0, 16'h00A5, '0, cg0, cg1);
    checks++; if ({cg0, cg1} !== 2'b01) begin errors++; $display("FAIL in_freeze_latency got %b want 01", {cg0, cg1}); end
    repeat (3) @(negedge clk);
    checks++; if (bus.congela !== 1'b1) begin errors++; $display("FAIL in_hold got %b want 1", bus.congela); end
    press(0, lat, we, wa);
    model_commit(1, 16'h00A5);
    checks++; if (lat !== REL_LAT) begin errors++; $display("FAIL in_release_latency got %0d want %0d", lat, REL_LAT); end
    checks++; if ({we, wa} !== 2'b10) begin errors++; $display("FAIL in_we_pulse got %b want 10", {we, wa}); end
    checks++; if (bus.in_data !== 32'h0000_00A5) begin errors++; $display("FAIL in_data got %h want 000000a5", bus.in_data); end
    checks++; if (bus.io_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL in_count got %h want %h", bus.io_count, CNT_W'(m_cnt)); end
  endtask

  task automatic test_out();
    logic cg0, cg1, we, wa; int lat;
    start_req(0, 1, '0, 32'hDEAD_BEEF, cg0, cg1);
    checks++; if ({cg0, cg1} !== 2'b01) begin errors++; $display("FAIL out_freeze_latency got %b want 01", {cg0, cg1}); end
    bus.out_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checks++; if (bus.disp_reg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_disp_hold got %h want deadbeef", bus.disp_reg); end
    press(0, lat, we, wa);
    model_commit(0, '0);
    checks++; if (lat !== REL_LAT) begin errors++; $display("FAIL out_release_latency got %0d want %0d", lat, REL_LAT); end
    checks++; if ({we, wa} !== 2'b00) begin errors++; $display("FAIL out_no_we got %b want 00", {we, wa}); end
    checks++; if (bus.disp_reg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out_disp_after got %h want deadbeef", bus.disp_reg); end
    checks++; if (bus.io_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL out_count got %h want %h", bus.io_count, CNT_W'(m_cnt)); end
  endtask

  task automatic test_held_key();
    logic cg0, cg1, we, wa; int lat;
    bus.botao = 1'b1;
    repeat (SETTLE) @(negedge clk);
    start_req(1, 0, 16'h1234, '0, cg0, cg1);
    repeat (REL_LAT + 6) @(negedge clk);
    checks++; if (bus.congela !== 1'b1) begin errors++; $display("FAIL held_key_no_release got %b want 1", bus.congela); end
    bus.botao = 1'b0;
    repeat (SETTLE) @(negedge clk);
    checks++; if (bus.congela !== 1'b1) begin errors++; $display("FAIL held_key_release_edge got %b want 1", bus.congela); end
    press(0, lat, we, wa);
    model_commit(1, 16'h1234);
    checks++; if (lat !== REL_LAT) begin errors++; $display("FAIL held_key_repress got %0d want %0d", lat, REL_LAT); end
    checks++; if (bus.in_data !== m_in) begin errors++; $display("FAIL held_key_data got %h want %h", bus.in_data, m_in); end
  endtask

  task automatic test_conflict();
    logic cg0, cg1, we, wa; int lat;
    start_req(1, 1, 16'h0F0F, 32'hCAFE_0000, cg0, cg1);
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL conflict_set got %b want 1", bus.conflict); end
    press(0, lat, we, wa);
    model_commit(1, 16'h0F0F);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL conflict_in_wins_we got %b want 1", we); end
    checks++; if (bus.disp_reg !== m_disp) begin errors++; $display("FAIL conflict_disp got %h want %h", bus.disp_reg, m_disp); end
    start_req(0, 1, '0, 32'h0000_0042, cg0, cg1);
    press(0, lat, we, wa);
    model_commit(0, '0);
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky got %b want 1", bus.conflict); end
    checks++; if (bus.disp_reg !== 32'h0000_0042) begin errors++; $display("FAIL conflict_next_out got %h want 00000042", bus.disp_reg); end
  endtask

  task automatic test_back_to_back();
    logic cg0, cg1, we, wa; int lat;
    start_req(1, 0, 16'hAAAA, '0, cg0, cg1);
    press(1, lat, we, wa);
    model_commit(1, 16'hAAAA);
    checks++; if (bus.congela !== 1'b1) begin errors++; $display("FAIL b2b_refreeze got %b want 1", bus.congela); end
    bus.switches = 16'h5555;
    repeat (REL_LAT + 4) @(negedge clk);
    checks++; if (bus.io_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL b2b_no_reuse got %h want %h", bus.io_count, CNT_W'(m_cnt)); end
    press(0, lat, we, wa);
    model_commit(1, 16'h5555);
    checks++; if (bus.in_data !== m_in) begin errors++; $display("FAIL b2b_second_data got %h want %h", bus.in_data, m_in); end
    checks++; if (bus.io_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL b2b_count got %h want %h", bus.io_count, CNT_W'(m_cnt)); end
  endtask

  task automatic test_reset_mid();
    logic cg0, cg1;
    start_req(0, 1, '0, 32'hA5A5_0001, cg0, cg1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.congela !== 1'b0) begin errors++; $display("FAIL midreset_congela got %b want 0", bus.congela); end
    checks++; if (bus.disp_reg !== '0) begin errors++; $display("FAIL midreset_disp got %h want 0", bus.disp_reg); end
    checks++; if (bus.io_count !== '0) begin errors++; $display("FAIL midreset_count got %h want 0", bus.io_count); end
    bus.req_out = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_clear();
    checks++; if (bus.congela !== 1'b0) begin errors++; $display("FAIL midreset_idle got %b want 0", bus.congela); end
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_debounce();
    logic cg0, cg1, we, wa; int lat;
    start_req(1, 0, 16'h0003, '0, cg0, cg1);
    bus.botao = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    bus.botao = 1'b0;
    repeat (SETTLE + 4) @(negedge clk);
    checks++; if (bus.congela !== 1'b1) begin errors++; $display("FAIL deb_glitch_ignored got %b want 1", bus.congela); end
    press(0, lat, we, wa);
    model_commit(1, 16'h0003);
    checks++; if (lat !== REL_LAT) begin errors++; $display("FAIL deb_accept got %0d want %0d", lat, REL_LAT); end
  endtask
`endif

  task automatic test_wrap();
    logic cg0, cg1, we, wa; int lat;
    do_reset();
    for (int i = 0; i < (1 << CNT_W); i++) begin
      start_req(0, 1, '0, DATA_W'(i), cg0, cg1);
      press(0, lat, we, wa);
      model_commit(0, '0);
      if (i == (1 << CNT_W) - 2) begin
        checks++; if (bus.io_count !== '1) begin errors++; $display("FAIL wrap_max got %h want all-ones", bus.io_count); end
      end
    end
    checks++; if (bus.io_count !== '0) begin errors++; $display("FAIL wrap_zero got %h want 0", bus.io_count); end
  endtask

  task automatic test_random();
    logic cg0, cg1, we, wa; int lat; int k;
    bit ri, ro;
    logic [SW_W-1:0] sw; logic [DATA_W-1:0] od;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 9);
      ri = (k <= 5); ro = (k == 0) || (k >= 6);
      sw = SW_W'($urandom); od = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_req(ri, ro, sw, od, cg0, cg1);
      bus.out_data = $urandom;
      bus.switches = sw;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      press(0, lat, we, wa);
      model_commit(ri, sw);
      checks++;
      if (cg1 !== 1'b1 || lat !== REL_LAT || we !== logic'(ri) || wa !== 1'b0 ||
          bus.in_data !== m_in || bus.disp_reg !== m_disp ||
          bus.io_count !== CNT_W'(m_cnt) || bus.conflict !== m_conf) begin
        errors++;
        $display("FAIL random_op%0d got cg=%b lat=%0d we=%b%b in=%h disp=%h cnt=%h conf=%b want cg=1 lat=%0d we=%b0 in=%h disp=%h cnt=%h conf=%b",
                 i, cg1, lat, we, wa, bus.in_data, bus.disp_reg, bus.io_count, bus.conflict,
                 REL_LAT, ri, m_in, m_disp, CNT_W'(m_cnt), m_conf);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_in = 1'b0; bus.req_out = 1'b0; bus.botao = 1'b0;
    bus.switches = '0; bus.out_data = '0;
    model_clear();
    test_reset();
    test_in();
    test_out();
    test_held_key();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
`ifdef IO_DEBOUNCE_EN
    test_debounce();
`endif
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
